tick_timer_sched: RTL and testbench

Shared millisecond-tick timer scheduler. Runs one prescaler off the system clock and produces a single-cycle `tick` every TICK_DIV clocks. It serves NCH one-shot delay channels, each counting a requested number of ticks. Channel start requests share a single load port through a round-robin arbiter. It sits between the board clock and the game-logic blocks that need timed delays, so no block has to carry its own divider.

---
 rtl/tick_timer_sched.sv | 153 +++++++++++++++
 tb/tb_tick_timer_sched.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tick_timer_sched.sv
// Shared tick prescaler feeding NCH one-shot delay channels loaded through a round-robin arbiter.
// Latency: req -> ack next cycle; done one cycle after the expiring tick (zero delay: cycle after ack).
// Backpressure: requesters hold req until ack; one grant per cycle; optional TICK_CLKOUT_EN adds clk_slow.
module tick_timer_sched #(
    parameter int TICK_DIV = 50000,
    parameter int NCH      = 4,
    parameter int CNT_W    = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic [NCH-1:0]       req,
    input  logic [NCH*CNT_W-1:0] dly,
    output logic [NCH-1:0]       ack,
    output logic [NCH-1:0]       busy,
    output logic [NCH-1:0]       done,
    output logic                 tick
`ifdef TICK_CLKOUT_EN
    ,
    output logic                 clk_slow
`endif
);

    localparam int PSC_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam int PTR_W = (NCH > 1) ? $clog2(NCH) : 1;

    logic [PSC_W-1:0]            psc_q, psc_d;
    logic                        tick_q, tick_d;
    logic [PTR_W-1:0]            ptr_q, ptr_d;
    logic [NCH-1:0]              ack_q, ack_d;
    logic [NCH-1:0]              busy_q, busy_d;
    logic [NCH-1:0]              done_q, done_d;
    logic [NCH-1:0]              zpend_q, zpend_d;
    logic [NCH-1:0][CNT_W-1:0]   cnt_q, cnt_d;

    logic [NCH-1:0]              elig;
    logic                        gnt_vld;
    logic [PTR_W-1:0]            gnt_idx;
    logic [CNT_W-1:0]            dly_v;

    // Prescaler: count while enabled, emit a registered tick after the terminal count.
    always_comb begin
        psc_d  = psc_q;
        tick_d = 1'b0;
        if (!en) begin
            psc_d = '0;
        end else if (psc_q == PSC_W'(TICK_DIV - 1)) begin
            psc_d  = '0;
            tick_d = 1'b1;
        end else begin
            psc_d = psc_q + PSC_W'(1);
        end
    end

    // Round-robin pick: lowest eligible index at/above the pointer, else lowest overall (wrap).
    always_comb begin
        elig    = req & ~ack_q;
        gnt_vld = 1'b0;
        gnt_idx = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (elig[i] && (i >= int'(ptr_q))) begin
                gnt_vld = 1'b1;
                gnt_idx = PTR_W'(i);
            end
        end
        if (!gnt_vld) begin
            for (int i = NCH - 1; i >= 0; i--) begin
                if (elig[i]) begin
                    gnt_vld = 1'b1;
                    gnt_idx = PTR_W'(i);
                end
            end
        end
        ack_d = '0;
        ptr_d = ptr_q;
        if (gnt_vld) begin
            ack_d = NCH'(1) << gnt_idx;
            ptr_d = (gnt_idx == PTR_W'(NCH - 1)) ? '0 : gnt_idx + PTR_W'(1);
        end
    end

    // Channels: a load wins over a same-cycle decrement; zero delay defers done by one cycle
    // so it lands in the cycle after ack.
    always_comb begin
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = zpend_q;
        zpend_d = '0;
        dly_v   = '0;
        for (int i = 0; i < NCH; i++) begin
            dly_v = dly[i*CNT_W +: CNT_W];
            if (ack_d[i]) begin
                cnt_d[i] = dly_v;
                if (dly_v != '0) begin
                    busy_d[i] = 1'b1;
                end else begin
                    busy_d[i]  = 1'b0;
                    zpend_d[i] = 1'b1;
                end
            end else if (tick_q && busy_q[i]) begin
                cnt_d[i] = cnt_q[i] - CNT_W'(1);
                if (cnt_q[i] == CNT_W'(1)) begin
                    busy_d[i] = 1'b0;
                    done_d[i] = 1'b1;
                end
            end
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            psc_q   <= '0;
            tick_q  <= 1'b0;
            ptr_q   <= '0;
            ack_q   <= '0;
            busy_q  <= '0;
            done_q  <= '0;
            zpend_q <= '0;
            cnt_q   <= '0;
        end else begin
            psc_q   <= psc_d;
            tick_q  <= tick_d;
            ptr_q   <= ptr_d;
            ack_q   <= ack_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            zpend_q <= zpend_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef TICK_CLKOUT_EN
    logic clk_slow_q;

    // Legacy slow clock: flip on every edge that samples a tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_slow_q <= 1'b0;
        end else if (tick_q) begin
            clk_slow_q <= ~clk_slow_q;
        end
    end

    assign clk_slow = clk_slow_q;
`endif

    assign ack  = ack_q;
    assign busy = busy_q;
    assign done = done_q;
    assign tick = tick_q;

endmodule

// File: tb/tb_tick_timer_sched.sv
// Directed bench for tick_timer_sched with TICK_DIV=4, NCH=4, CNT_W=8.
// Inputs driven 1ns after the rising edge; outputs sampled there too.
// Summary line reports comparisons and failures.
module tb_tick_timer_sched;

    localparam int TICK_DIV = 4;
    localparam int NCH      = 4;
    localparam int CNT_W    = 8;

    logic                 clk;
    logic                 rst_n;
    logic                 en;
    logic [NCH-1:0]       req;
    logic [NCH*CNT_W-1:0] dly;
    logic [NCH-1:0]       ack;
    logic [NCH-1:0]       busy;
    logic [NCH-1:0]       done;
    logic                 tick;
`ifdef TICK_CLKOUT_EN
    logic                 clk_slow;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    tick_timer_sched #(
        .TICK_DIV(TICK_DIV),
        .NCH     (NCH),
        .CNT_W   (CNT_W)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en),
        .req     (req),
        .dly     (dly),
        .ack     (ack),
        .busy    (busy),
        .done    (done),
        .tick    (tick)
`ifdef TICK_CLKOUT_EN
        ,
        .clk_slow(clk_slow)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic exp_tick;
        logic exp_slow;
        rst_n = 1'b0; en = 1'b0; req = '0; dly = '0;
        step(); step();
        rst_n = 1'b1;
        en    = 1'b1;
        for (int i = 0; i < 6; i++) step();
        req = 4'b1111;
        dly = {8'd3, 8'd3, 8'd3, 8'd3};
        #3;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({ack, busy, done, tick} !== 13'd0) begin
            n_fail++;
            $display("FAIL reset_async: ack=%b busy=%b done=%b tick=%b, required all 0", ack, busy, done, tick);
        end
        step(); step();
        n_checks++;
        if ({ack, busy, done, tick} !== 13'd0) begin
            n_fail++;
            $display("FAIL reset_held: ack=%b busy=%b done=%b tick=%b, required all 0", ack, busy, done, tick);
        end
`ifdef TICK_CLKOUT_EN
        n_checks++;
        if (clk_slow !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_clk_slow: got %b, required 0", clk_slow);
        end
`endif
        req = '0; dly = '0; en = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        en = 1'b1;
        exp_slow = 1'b0;
        exp_tick = 1'b0;
        for (int n = 1; n <= 9; n++) begin
            step();
            if (exp_tick) exp_slow = ~exp_slow;
            exp_tick = (n == 4) || (n == 8);
            n_checks++;
            if (tick !== exp_tick) begin
                n_fail++;
                $display("FAIL first_tick n=%0d: tick=%b, required %b", n, tick, exp_tick);
            end
`ifdef TICK_CLKOUT_EN
            n_checks++;
            if (clk_slow !== exp_slow) begin
                n_fail++;
                $display("FAIL clk_slow n=%0d: got %b, required %b", n, clk_slow, exp_slow);
            end
`endif
        end
    endtask

    task automatic test_contention();
        logic [NCH-1:0] exp_ack;
        dly = {8'd1, 8'd1, 8'd1, 8'd1};
        req = 4'b1111;
        for (int g = 0; g < NCH; g++) begin
            step();
            exp_ack = 4'b0001 << g;
            n_checks++;
            if (ack !== exp_ack) begin
                n_fail++;
                $display("FAIL contention_grant%0d: ack=%b, required %b", g, ack, exp_ack);
            end
            req = req & ~exp_ack;
        end
        step();
        n_checks++;
        if (ack !== 4'b0000) begin
            n_fail++;
            $display("FAIL contention_idle: ack=%b, required 0000", ack);
        end
        req = 4'b1001;
        step();
        n_checks++;
        if (ack !== 4'b0001) begin
            n_fail++;
            $display("FAIL wrap_first: ack=%b, required 0001", ack);
        end
        req = 4'b1000;
        step();
        n_checks++;
        if (ack !== 4'b1000) begin
            n_fail++;
            $display("FAIL wrap_second: ack=%b, required 1000", ack);
        end
        req = 4'b0000;
        step();
        n_checks++;
        if (ack !== 4'b0000) begin
            n_fail++;
            $display("FAIL wrap_idle: ack=%b, required 0000", ack);
        end
        for (int i = 0; i < 20; i++) step();
    endtask

    task automatic test_single();
        int ticks, t3, td, ndone;
        logic busy_at_t3;
        dly = '0;
        dly[1*CNT_W +: CNT_W] = 8'd3;
        req = 4'b0010;
        step();
        n_checks++;
        if (ack !== 4'b0010 || busy[1] !== 1'b1) begin
            n_fail++;
            $display("FAIL single_ack: ack=%b busy=%b, required ack 0010 busy[1]=1", ack, busy);
        end
        req = '0;
        ticks = 0; t3 = -1; td = -1; ndone = 0; busy_at_t3 = 1'b0;
        for (int n = 0; n < 40; n++) begin
            if (n > 0) step();
            if (done[1]) begin
                ndone++;
                if (td < 0) td = n;
                n_checks++;
                if (busy[1] !== 1'b0) begin
                    n_fail++;
                    $display("FAIL single_busy_fall: busy[1]=%b at done, required 0", busy[1]);
                end
            end
            if (tick) begin
                ticks++;
                if (ticks == 3) begin
                    t3 = n;
                    busy_at_t3 = busy[1];
                end
            end
        end
        n_checks++;
        if (ndone != 1 || t3 < 0 || td != t3 + 1) begin
            n_fail++;
            $display("FAIL single_done: pulses=%0d at cycle %0d, required 1 pulse at cycle %0d", ndone, td, t3 + 1);
        end
        n_checks++;
        if (busy_at_t3 !== 1'b1) begin
            n_fail++;
            $display("FAIL single_busy_hold: busy[1]=%b on 3rd tick, required 1", busy_at_t3);
        end
    endtask

    task automatic test_zero_delay();
        dly = '0;
        req = 4'b0100;
        step();
        n_checks++;
        if (ack !== 4'b0100 || busy[2] !== 1'b0 || done !== 4'b0000) begin
            n_fail++;
            $display("FAIL zero_ack: ack=%b busy=%b done=%b, required 0100/busy2=0/0000", ack, busy, done);
        end
        req = '0;
        step();
        n_checks++;
        if (done !== 4'b0100 || busy[2] !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_done: done=%b busy=%b, required done 0100 busy2=0", done, busy);
        end
        step();
        n_checks++;
        if (done !== 4'b0000) begin
            n_fail++;
            $display("FAIL zero_done_clear: done=%b, required 0000", done);
        end
    endtask

    task automatic test_retrigger();
        int ticks, rl, ticks2, t2, td, ndone;
        dly = '0;
        dly[0 +: CNT_W] = 8'd5;
        req = 4'b0001;
        step();
        n_checks++;
        if (ack !== 4'b0001 || busy[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL retrig_load: ack=%b busy=%b, required ack 0001 busy[0]=1", ack, busy);
        end
        req = '0;
        ticks = 0; rl = -1; ticks2 = 0; t2 = -1; td = -1; ndone = 0;
        for (int n = 0; n < 60; n++) begin
            if (n > 0) step();
            if (rl >= 0 && n == rl + 1) begin
                n_checks++;
                if (ack !== 4'b0001 || busy[0] !== 1'b1) begin
                    n_fail++;
                    $display("FAIL retrig_reload: ack=%b busy=%b, required ack 0001 busy[0]=1", ack, busy);
                end
                req = '0;
            end
            if (done[0]) begin
                ndone++;
                td = n;
            end
            if (tick) begin
                if (rl < 0) begin
                    ticks++;
                    if (ticks == 4) begin
                        rl = n;
                        dly[0 +: CNT_W] = 8'd2;
                        req = 4'b0001;
                    end
                end else if (n > rl) begin
                    ticks2++;
                    if (ticks2 == 2) t2 = n;
                end
            end
        end
        n_checks++;
        if (ndone != 1 || t2 < 0 || td != t2 + 1) begin
            n_fail++;
            $display("FAIL retrig_done: pulses=%0d last at cycle %0d, required 1 pulse at cycle %0d", ndone, td, t2 + 1);
        end
    endtask

    initial begin
        test_reset();
        test_contention();
        test_single();
        test_zero_delay();
        test_retrigger();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
